// File: rtl/number_cam_pkg.sv
// number_cam_pkg: shared constants, index-width helper and lookup result type
// for the memory-game number store.
package number_cam_pkg;

    localparam int unsigned DEF_WIDTH = 10;
    localparam int unsigned DEF_DEPTH = 10;

    // Widest index the store supports (DEPTH up to 64).
    localparam int unsigned IDX_MAX = 6;

    // Index/pointer width for a given depth; DEPTH is at least 2, so this is at least 1.
    function automatic int unsigned idxw_f(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Result of a key search: hit flag plus lowest matching entry index.
    typedef struct packed {
        logic               hit;
        logic [IDX_MAX-1:0] idx;
    } lk_res_t;

endpackage

// File: rtl/number_cam_match.sv
// number_cam_match: compares a key against every valid entry and returns
// the hit flag with the lowest matching index (idx = 0 on miss).
module number_cam_match
    import number_cam_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic [WIDTH-1:0]       i_key,
    input  logic [DEPTH-1:0]       i_vld,
    input  logic [DEPTH*WIDTH-1:0] i_mem,
    output lk_res_t                o_res
);

    logic               w_hit;
    logic [IDX_MAX-1:0] w_idx;

    // Scan upward; the first valid match wins so the lowest index is reported.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!w_hit && i_vld[i] && (i_mem[i*WIDTH +: WIDTH] == i_key)) begin
                w_hit = 1'b1;
                w_idx = IDX_MAX'(i);
            end
        end
    end

    assign o_res.hit = w_hit;
    assign o_res.idx = w_idx;

endmodule

// File: rtl/number_cam.sv
// number_cam: append-only store of previously seen numbers with duplicate
// rejection and a registered, fully pipelined lookup.
// Optional macro NUMBER_CAM_HITCNT_EN adds the saturating hit_cnt output.
module number_cam
    import number_cam_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned IDXW  = idxw_f(DEPTH)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            flush,
    input  logic            ins_valid,
    input  logic [WIDTH-1:0] ins_data,
    output logic            ins_ready,
    output logic            ins_dup,
    input  logic            lk_valid,
    input  logic [WIDTH-1:0] lk_data,
    output logic            lk_done,
    output logic            lk_hit,
    output logic [IDXW-1:0] lk_idx,
    output logic [IDXW:0]   count,
    output logic            full,
    output logic            empty
`ifdef NUMBER_CAM_HITCNT_EN
    ,
    output logic [IDXW+1:0] hit_cnt
`endif
);

    logic [DEPTH*WIDTH-1:0] r_mem;
    logic [DEPTH-1:0]       r_vld;
    // Entries are never removed individually, so the append pointer always
    // equals the entry count; one register serves as both.
    logic [IDXW:0]          r_count;
    logic                   r_ins_dup;
    logic                   r_lk_done;
    logic                   r_lk_hit;
    logic [IDXW-1:0]        r_lk_idx;

    lk_res_t w_ins_res;
    lk_res_t w_lk_res;
    logic    w_full;
    logic    w_ins_acc;
    logic    w_wr_en;

    number_cam_match #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ins_match (
        .i_key (ins_data),
        .i_vld (r_vld),
        .i_mem (r_mem),
        .o_res (w_ins_res)
    );

    number_cam_match #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lk_match (
        .i_key (lk_data),
        .i_vld (r_vld),
        .i_mem (r_mem),
        .o_res (w_lk_res)
    );

    assign w_full    = (r_count == (IDXW+1)'(DEPTH));
    assign w_ins_acc = ins_valid && !w_full && !flush;
    assign w_wr_en   = w_ins_acc && !w_ins_res.hit;

    // Entry data is don't-care until its valid bit is set, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_wr_en && (r_count == (IDXW+1)'(i))) begin
                r_mem[i*WIDTH +: WIDTH] <= ins_data;
            end
        end
    end

    // Valid bits and count: flush clears everything, otherwise append on a new value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_vld   <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_vld   <= '0;
            r_count <= '0;
        end else if (w_wr_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r_count == (IDXW+1)'(i)) begin
                    r_vld[i] <= 1'b1;
                end
            end
            r_count <= r_count + 1'b1;
        end
    end

    // Duplicate pulse for an accepted insert whose value is already stored.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ins_dup <= 1'b0;
        end else begin
            r_ins_dup <= w_ins_acc && w_ins_res.hit;
        end
    end

    // Lookup result register; searches pre-update contents, unaffected by flush.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_lk_done <= 1'b0;
            r_lk_hit  <= 1'b0;
            r_lk_idx  <= '0;
        end else begin
            r_lk_done <= lk_valid;
            if (lk_valid) begin
                r_lk_hit <= w_lk_res.hit;
                r_lk_idx <= w_lk_res.idx[IDXW-1:0];
            end
        end
    end

`ifdef NUMBER_CAM_HITCNT_EN
    logic [IDXW+1:0] r_hit_cnt;

    // Saturating count of lookups that reported a hit.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hit_cnt <= '0;
        end else if (flush) begin
            r_hit_cnt <= '0;
        end else if (r_lk_done && r_lk_hit && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign hit_cnt = r_hit_cnt;
`endif

    assign ins_ready = !w_full;
    assign ins_dup   = r_ins_dup;
    assign lk_done   = r_lk_done;
    assign lk_hit    = r_lk_hit;
    assign lk_idx    = r_lk_idx;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = (r_count == '0);

endmodule

// File: tb/tb_number_cam.sv
// tb_number_cam: directed self-checking bench for number_cam (WIDTH=10, DEPTH=10).
module tb_number_cam;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned DEPTH = 10;
    localparam int unsigned IDXW  = 4;

    logic             clk = 1'b0;
    logic             clr;
    logic             flush;
    logic             ins_valid;
    logic [WIDTH-1:0] ins_data;
    logic             ins_ready;
    logic             ins_dup;
    logic             lk_valid;
    logic [WIDTH-1:0] lk_data;
    logic             lk_done;
    logic             lk_hit;
    logic [IDXW-1:0]  lk_idx;
    logic [IDXW:0]    count;
    logic             full;
    logic             empty;
`ifdef NUMBER_CAM_HITCNT_EN
    logic [IDXW+1:0]  hit_cnt;
`endif

    int errors = 0;
    int checks = 0;

    number_cam #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .ins_valid (ins_valid),
        .ins_data  (ins_data),
        .ins_ready (ins_ready),
        .ins_dup   (ins_dup),
        .lk_valid  (lk_valid),
        .lk_data   (lk_data),
        .lk_done   (lk_done),
        .lk_hit    (lk_hit),
        .lk_idx    (lk_idx),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef NUMBER_CAM_HITCNT_EN
        ,
        .hit_cnt   (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; flush = 1'b0; ins_valid = 1'b0; ins_data = '0;
        lk_valid = 1'b0; lk_data = '0;
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ready", 32'(ins_ready), 1);
        chk("rst_dup", 32'(ins_dup), 0);
        chk("rst_done", 32'(lk_done), 0);
        chk("rst_hit", 32'(lk_hit), 0);
        chk("rst_idx", 32'(lk_idx), 0);
        tick();
        clr = 1'b0;

        // 1: insert 5, 9, 3
        ins_valid = 1'b1; ins_data = 10'd5; tick();
        ins_data = 10'd9; tick();
        ins_data = 10'd3; tick();
        ins_valid = 1'b0;
        chk("t1_count", 32'(count), 3);
        chk("t1_empty", 32'(empty), 0);
        lk_valid = 1'b1; lk_data = 10'd0; tick();
        chk("t1_lk0_done", 32'(lk_done), 1);
        chk("t1_lk0_hit", 32'(lk_hit), 0);
        chk("t1_lk0_idx", 32'(lk_idx), 0);
        lk_data = 10'd9; tick();
        chk("t1_lk9_done", 32'(lk_done), 1);
        chk("t1_lk9_hit", 32'(lk_hit), 1);
        chk("t1_lk9_idx", 32'(lk_idx), 1);
        lk_valid = 1'b0; tick();
        chk("t1_idle_done", 32'(lk_done), 0);
        chk("t1_hold_hit", 32'(lk_hit), 1);
        chk("t1_hold_idx", 32'(lk_idx), 1);

        // 2: duplicate insert of 9
        ins_valid = 1'b1; ins_data = 10'd9; tick();
        ins_valid = 1'b0;
        chk("t2_dup", 32'(ins_dup), 1);
        chk("t2_count", 32'(count), 3);
        lk_valid = 1'b1; lk_data = 10'd9; tick();
        lk_valid = 1'b0;
        chk("t2_dup_pulse", 32'(ins_dup), 0);
        chk("t2_lk9_hit", 32'(lk_hit), 1);
        chk("t2_lk9_idx", 32'(lk_idx), 1);

        // 4: insert 42 and look it up in the same cycle
        ins_valid = 1'b1; ins_data = 10'd42; lk_valid = 1'b1; lk_data = 10'd42; tick();
        ins_valid = 1'b0;
        chk("t4_same_hit", 32'(lk_hit), 0);
        chk("t4_count", 32'(count), 4);
        chk("t4_nodup", 32'(ins_dup), 0);
        tick();
        lk_valid = 1'b0;
        chk("t4_next_hit", 32'(lk_hit), 1);
        chk("t4_next_idx", 32'(lk_idx), 3);

        // 3: fill to DEPTH with 10..15
        ins_valid = 1'b1;
        for (int v = 10; v < 16; v++) begin
            ins_data = 10'(v);
            tick();
        end
        chk("t3_count", 32'(count), 10);
        chk("t3_full", 32'(full), 1);
        chk("t3_ready", 32'(ins_ready), 0);
        ins_data = 10'd77; tick();
        ins_valid = 1'b0;
        chk("t3_full_nodup", 32'(ins_dup), 0);
        chk("t3_full_count", 32'(count), 10);
        lk_valid = 1'b1; lk_data = 10'd77; tick();
        chk("t3_lk77_hit", 32'(lk_hit), 0);
        lk_data = 10'd15; tick();
        lk_valid = 1'b0;
        chk("t3_lk15_hit", 32'(lk_hit), 1);
        chk("t3_lk15_idx", 32'(lk_idx), 9);

        // 5: flush + insert 8 + lookup 5 together
        flush = 1'b1; ins_valid = 1'b1; ins_data = 10'd8; lk_valid = 1'b1; lk_data = 10'd5; tick();
        flush = 1'b0; ins_valid = 1'b0;
        chk("t5_done", 32'(lk_done), 1);
        chk("t5_hit", 32'(lk_hit), 1);
        chk("t5_idx", 32'(lk_idx), 0);
        chk("t5_count", 32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_full", 32'(full), 0);
        chk("t5_nodup", 32'(ins_dup), 0);
        tick();
        chk("t5_lk5_miss", 32'(lk_hit), 0);
        lk_data = 10'd8; tick();
        lk_valid = 1'b0;
        chk("t5_lk8_miss", 32'(lk_hit), 0);

        // 6: asynchronous clr in the middle of back-to-back lookups
        ins_valid = 1'b1;
        ins_data = 10'd1; tick();
        ins_data = 10'd2; tick();
        ins_data = 10'd3; tick();
        ins_valid = 1'b0;
        lk_valid = 1'b1; lk_data = 10'd2; tick();
        chk("t6_pre_done", 32'(lk_done), 1);
        chk("t6_pre_idx", 32'(lk_idx), 1);
        #2;
        clr = 1'b1;
        #1;
        chk("t6_clr_done", 32'(lk_done), 0);
        chk("t6_clr_hit", 32'(lk_hit), 0);
        chk("t6_clr_idx", 32'(lk_idx), 0);
        chk("t6_clr_count", 32'(count), 0);
        chk("t6_clr_empty", 32'(empty), 1);
`ifdef NUMBER_CAM_HITCNT_EN
        chk("t6_clr_hitcnt", 32'(hit_cnt), 0);
`endif
        lk_valid = 1'b0;
        tick();
        clr = 1'b0;
        ins_valid = 1'b1;
        ins_data = 10'd1; tick();
        ins_data = 10'd2; tick();
        ins_data = 10'd3; tick();
        ins_valid = 1'b0;
        lk_valid = 1'b1;
        lk_data = 10'd1; tick();
        lk_data = 10'd2; tick();
        lk_data = 10'd3; tick();
        lk_valid = 1'b0;
        chk("t6_lk3_hit", 32'(lk_hit), 1);
        chk("t6_lk3_idx", 32'(lk_idx), 2);
        tick();
`ifdef NUMBER_CAM_HITCNT_EN
        chk("t6_hitcnt3", 32'(hit_cnt), 3);
`endif
        chk("t6_count", 32'(count), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
